// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM sequencer and its round-robin arbiter.
package sram_arbiter_pkg;

  // Access sequence: one setup cycle, a strobe window, one hold cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int SRAM_ADDR_W = 17;
  localparam int SRAM_DATA_W = 8;
  localparam int WAIT_CNT_W  = 4;

  // CE_n is asserted for every state that belongs to an access.
  function automatic logic bus_active(input state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-requester round-robin grant. The last-grant flop only moves when the
// sequencer actually starts an access, so a tie always favours the port
// that was not served most recently.
module sram_rr_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant
);

  logic last_grant_q;
  logic last_grant_d;

  // Winner selection: a lone requester wins, a tie goes to the other port.
  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last_grant_q;
    end else if (req1) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

  // Remember the winner only when the grant is consumed.
  always_comb begin
    last_grant_d = last_grant_q;
    if (update) begin
      last_grant_d = grant;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant register; reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Sequencer for the asynchronous 128K x 8 SRAM. Serialises single-byte
// accesses from two ports and drives every SRAM pin from a flop, so strobes
// and the DQ enable only change on clock edges.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_n,
  output logic              SRAM_OE_n,
  output logic              SRAM_WE_n
);

  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                  dq_oe_q, dq_oe_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  grant_s, leave_idle_s, capture_s;

  assign leave_idle_s = (state_q == IDLE) && (m0_req || m1_req);
  assign capture_s    = (state_q == STROBE) && (cnt_q == {WAIT_CNT_W{1'b0}}) && !we_q;

  sram_rr_arbiter u_rr (
    .clk    (clk),
    .reset  (reset),
    .req0   (m0_req),
    .req1   (m1_req),
    .update (leave_idle_s),
    .grant  (grant_s)
  );

  // Next state and strobe-window down-counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) state_d = SETUP;
        else                  state_d = IDLE;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = WAIT_CNT_W'(WAIT_CYCLES - 1);
      end
      STROBE: begin
        if (cnt_q == {WAIT_CNT_W{1'b0}}) begin
          state_d = HOLD;
        end else begin
          state_d = STROBE;
          cnt_d   = cnt_q - WAIT_CNT_W'(1);
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winning port's request when leaving IDLE; ignore inputs afterwards.
  always_comb begin
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (leave_idle_s) begin
      port_d = grant_s;
      if (grant_s) begin
        we_d    = m1_we;
        addr_d  = m1_addr;
        wdata_d = m1_wdata;
      end else begin
        we_d    = m0_we;
        addr_d  = m0_addr;
        wdata_d = m0_wdata;
      end
    end else begin
      port_d = port_q;
    end
  end

  // Pin and ack values for the coming cycle, decoded from the next state.
  always_comb begin
    ce_n_d   = ~bus_active(state_d);
    oe_n_d   = ~((state_d == STROBE) && !we_d);
    we_n_d   = ~((state_d == STROBE) && we_d);
    dq_oe_d  = bus_active(state_d) && we_d;
    ack0_d   = (state_d == HOLD) && !port_d;
    ack1_d   = (state_d == HOLD) && port_d;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (capture_s) begin
      if (port_q) rdata1_d = SRAM_DQ;
      else        rdata0_d = SRAM_DQ;
    end else begin
      rdata0_d = rdata0_q;
    end
  end

  // FSM state and counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {WAIT_CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched request; addr_q doubles as the SRAM address pin register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
    end else begin
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Strobe, DQ-enable, ack and read-data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= {DATA_W{1'b0}};
      rdata1_q <= {DATA_W{1'b0}};
    end else begin
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      dq_oe_q  <= dq_oe_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_n = ce_n_q;
  assign SRAM_OE_n = oe_n_q;
  assign SRAM_WE_n = we_n_q;
  assign m0_ack    = ack0_q;
  assign m1_ack    = ack1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM pin model, transaction-level reference model
// predicting grant order, pin windows and read data, plus WAIT_CYCLES=1/15
// latency instances.
module tb_sram_arbiter;

  localparam int W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        m0_req, m1_req, m0_we, m1_we;
  logic [16:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  wire         m0_ack, m1_ack;
  wire  [7:0]  m0_rdata, m1_rdata;
  wire  [7:0]  dq;
  wire  [16:0] sram_addr;
  wire         ce_n, oe_n, we_n;
  logic [7:0]  sram_rd;

  // Latency-only instances
  logic        lreq;
  wire         l1_ack, l15_ack, l1_a1, l15_a1, l1_ce, l1_oe, l1_we, l15_ce, l15_oe, l15_we;
  wire  [7:0]  l1_rd0, l1_rd1, l15_rd0, l15_rd1, dq1, dq15;
  wire  [16:0] l1_addr, l15_addr;

  sram_arbiter #(.ADDR_W(17), .DATA_W(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .SRAM_DQ(dq), .SRAM_ADDR(sram_addr), .SRAM_CE_n(ce_n), .SRAM_OE_n(oe_n), .SRAM_WE_n(we_n));

  sram_arbiter #(.ADDR_W(17), .DATA_W(8), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .reset(reset),
    .m0_req(lreq), .m0_we(1'b0), .m0_addr(17'h00000), .m0_wdata(8'h00),
    .m0_ack(l1_ack), .m0_rdata(l1_rd0),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr(17'h00000), .m1_wdata(8'h00),
    .m1_ack(l1_a1), .m1_rdata(l1_rd1),
    .SRAM_DQ(dq1), .SRAM_ADDR(l1_addr), .SRAM_CE_n(l1_ce), .SRAM_OE_n(l1_oe), .SRAM_WE_n(l1_we));

  sram_arbiter #(.ADDR_W(17), .DATA_W(8), .WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .reset(reset),
    .m0_req(lreq), .m0_we(1'b0), .m0_addr(17'h00000), .m0_wdata(8'h00),
    .m0_ack(l15_ack), .m0_rdata(l15_rd0),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr(17'h00000), .m1_wdata(8'h00),
    .m1_ack(l15_a1), .m1_rdata(l15_rd1),
    .SRAM_DQ(dq15), .SRAM_ADDR(l15_addr), .SRAM_CE_n(l15_ce), .SRAM_OE_n(l15_oe), .SRAM_WE_n(l15_we));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- SRAM pin model ----------------
  logic [7:0] sram_mem [int];
  assign dq = (!ce_n && !oe_n) ? sram_rd : 8'hzz;

  always @(posedge clk) begin
    #2;
    sram_rd = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 8'h00;
  end

  always @(negedge clk) begin
    if (!ce_n && !we_n) sram_mem[int'(sram_addr)] = dq;
  end

  // ---------------- Reference model ----------------
  // Bus is a serial resource: an access granted at the edge ending cycle g
  // occupies cycles g+1..g+W+2 and the bus can be granted again at g+W+3.
  int          cyc = 0;
  int          g = 0;
  int          free_cyc = 0;
  bit          act = 1'b0;
  logic        last_p = 1'b1;
  logic        mp = 1'b0, mwe = 1'b0;
  logic [16:0] maddr = 17'h0;
  logic [7:0]  mwdata = 8'h00, mrd = 8'h00;
  logic [7:0]  exp_rd0 = 8'h00, exp_rd1 = 8'h00;
  logic [7:0]  ref_mem [int];
  int          ack_log [$];

  always @(posedge clk) begin
    int n;
    n = cyc;
    if (reset) begin
      act = 1'b0; free_cyc = 0; last_p = 1'b1; exp_rd0 = 8'h00; exp_rd1 = 8'h00;
    end else begin
      if (act && n == g + W + 1 && !mwe) begin
        if (mp) exp_rd1 = mrd;
        else    exp_rd0 = mrd;
      end
      if (act && n >= g + W + 2) act = 1'b0;
      if (!act && n >= free_cyc && (m0_req || m1_req)) begin
        if (m0_req && m1_req) mp = ~last_p;
        else                  mp = m1_req;
        last_p   = mp;
        act      = 1'b1;
        g        = n;
        free_cyc = n + W + 3;
        mwe      = mp ? m1_we    : m0_we;
        maddr    = mp ? m1_addr  : m0_addr;
        mwdata   = mp ? m1_wdata : m0_wdata;
        if (mwe) ref_mem[int'(maddr)] = mwdata;
        else     mrd = ref_mem.exists(int'(maddr)) ? ref_mem[int'(maddr)] : 8'h00;
      end
    end
    cyc = n + 1;
  end

  // Pin-level and ack/rdata checks every cycle, away from the active edge.
  always @(negedge clk) begin
    int k;
    bit win, strobe_c, hold_c;
    k        = cyc - g;
    win      = act && !reset && k >= 1 && k <= W + 2;
    strobe_c = win && k >= 2 && k <= W + 1;
    hold_c   = win && k == W + 2;
    check("ce_n", ce_n, !win);
    check("oe_n", oe_n, !(strobe_c && !mwe));
    check("we_n", we_n, !(strobe_c && mwe));
    check("m0_ack", m0_ack, hold_c && !mp);
    check("m1_ack", m1_ack, hold_c && mp);
    if (win)        check("sram_addr", sram_addr, maddr);
    else if (reset) check("sram_addr_rst", sram_addr, 17'h0);
    if (win && mwe)               check("dq_wdata", dq, mwdata);
    else if (!(strobe_c && !mwe)) check("dq_hiz", 32'(dq === 8'hzz), 32'd1);
    check("m0_rdata", m0_rdata, exp_rd0);
    check("m1_rdata", m1_rdata, exp_rd1);
    if (m0_ack) ack_log.push_back(0);
    if (m1_ack) ack_log.push_back(1);
  end

  // ---------------- Requester ----------------
  // Called at posedge+1; returns at posedge+1 after the edge following ack.
  task automatic port_txn(input int p, input logic we, input logic [16:0] a,
                          input logic [7:0] d, input bit corrupt);
    int t;
    if (p == 0) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (corrupt && t == 2) begin
        if (p == 0) begin m0_addr = ~a; m0_wdata = ~d; end
        else        begin m1_addr = ~a; m1_wdata = ~d; end
      end
      if ((p == 0 && m0_ack) || (p == 1 && m1_ack)) break;
    end
    check($sformatf("ack_wait%0d", p), 32'(t < 400), 32'd1);
    @(posedge clk); #1;
    if (p == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  task automatic rand_port(input int p, input int count);
    for (int i = 0; i < count; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      port_txn(p, 1'($urandom_range(0, 1)), 17'(17'h12340 + $urandom_range(0, 7)),
               8'($urandom), 1'b0);
    end
  endtask

  initial begin
    int lat1, lat15, t;
    reset = 1'b1; lreq = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 17'h0; m0_wdata = 8'h00;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 17'h0; m1_wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ce_n", ce_n, 1'b1);
    check("rst_rdata0", m0_rdata, 8'h00);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Directed write then read of the same byte from the other port.
    port_txn(0, 1'b1, 17'h12345, 8'hA5, 1'b0);
    port_txn(1, 1'b0, 17'h12345, 8'h00, 1'b0);
    check("rd_a5", m1_rdata, 8'hA5);

    // Both ports contend for three accesses each: strict alternation from port 0.
    ack_log.delete();
    fork
      for (int i = 0; i < 3; i++) port_txn(0, 1'(i % 2), 17'(17'h12340 + i), 8'(8'h10 + i), 1'b0);
      for (int j = 0; j < 3; j++) port_txn(1, 1'((j + 1) % 2), 17'(17'h12341 + j), 8'(8'h20 + j), 1'b0);
    join
    check("order_len", ack_log.size(), 6);
    for (int i = 0; i < 6 && i < ack_log.size(); i++)
      check($sformatf("order%0d", i), ack_log[i], i % 2);

    // Reset during a write strobe; both still pending afterwards, port 0 must win.
    fork
      port_txn(0, 1'b1, 17'h12350, 8'h3C, 1'b0);
      port_txn(1, 1'b0, 17'h12350, 8'h00, 1'b0);
      begin
        for (t = 0; t < 50; t++) begin
          @(negedge clk);
          if (!we_n) break;
        end
        check("we_strobe_seen", 32'(t < 50), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_ce_n", ce_n, 1'b1);
        check("rst_mid_we_n", we_n, 1'b1);
        check("rst_mid_dq", 32'(dq === 8'hzz), 32'd1);
        check("rst_mid_ack0", m0_ack, 1'b0);
        check("rst_mid_ack1", m1_ack, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
      end
    join
    check("rd_after_rst", m1_rdata, 8'h3C);

    // Inputs changed mid-access must not disturb the latched access; boundary addresses.
    port_txn(0, 1'b1, 17'h1FFFF, 8'h5A, 1'b1);
    port_txn(0, 1'b0, 17'h1FFFF, 8'h00, 1'b0);
    check("rd_top", m0_rdata, 8'h5A);
    port_txn(1, 1'b1, 17'h00000, 8'hFF, 1'b0);
    port_txn(0, 1'b0, 17'h00000, 8'h00, 1'b0);
    check("rd_zero", m0_rdata, 8'hFF);

    // Randomised traffic on a small address pool to exercise read-after-write.
    fork
      rand_port(0, 30);
      rand_port(1, 30);
    join

    // Latency for WAIT_CYCLES=1 and 15 builds.
    lat1 = 0; lat15 = 0;
    lreq = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (l1_ack && lat1 == 0)   lat1 = c;
      if (l15_ack && lat15 == 0) lat15 = c;
    end
    lreq = 1'b0;
    check("lat_w1", lat1, 3);
    check("lat_w15", lat15, 17);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequencing controller and two-port round-robin arbiter for the board's asynchronous 128K x 8 SRAM. Port 0 (CPU/Avalon-side bridge) and port 1 (display/buffer engine) issue single-byte read/write requests. The block grants one at a time and drives the SRAM pins with registered, glitch-free CE/OE/WE strobes and setup/hold margins. It replaces direct combinational pin drive and sits between the requesters and the top-level SRAM pads.

## Interface
- ADDR_W, 17, SRAM address width
- DATA_W, 8, SRAM data width
- WAIT_CYCLES, 2, cycles OE_n/WE_n held low per access; legal range 1..15
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req, m1_req  in  1  access request; held until matching ack
- m0_we, m1_we  in  1  1 = write, 0 = read; valid with req
- m0_addr, m1_addr  in  ADDR_W  byte address; valid with req
- m0_wdata, m1_wdata  in  DATA_W  write data; valid with req
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  DATA_W  registered read data; valid with ack, held until that port's next read completes
- SRAM_DQ  inout  DATA_W  data bus; driven only during write SETUP/STROBE/HOLD, else high-Z
- SRAM_ADDR  out  ADDR_W  registered address
- SRAM_CE_n, SRAM_OE_n, SRAM_WE_n  out  1  registered active-low strobes

## Operation
- FSM: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE: all strobes high, DQ high-Z. If any req is sampled, grant and latch that port's we/addr/wdata into internal registers, then go to SETUP.
- Arbitration: if only one port requests, it wins. If both request, the port not granted last wins. The last_grant reset value is 1, so port 0 wins the first tie.
- SETUP (1 cycle): CE_n=0, ADDR=latched address, OE_n=WE_n=1. On a write, DQ is driven with latched wdata.
- STROBE (WAIT_CYCLES cycles, down-counter): CE_n=0. Read: OE_n=0. Write: WE_n=0 with DQ driven.
  - On the last STROBE cycle of a read, SRAM_DQ is captured into the granted port's rdata register.
- HOLD (1 cycle): OE_n=WE_n=1, CE_n=0, ADDR unchanged, DQ still driven on write (data hold). The granted port's ack=1.
- After HOLD the FSM always returns to IDLE (one bus-idle cycle between accesses).
- Requester rule: req, we, addr and wdata are stable from assertion until ack.
  - Deassert req on the edge following ack, or keep it high to request again.
  - Ack never asserts on the non-granted port.
  - Inputs change after latching have no effect on the access in progress.
- Read and write to the same address in back-to-back grants: the read returns the newly written byte (accesses are strictly serialized).

## Timing
- Reset values: state IDLE, SRAM_CE_n=SRAM_OE_n=SRAM_WE_n=1, SRAM_ADDR=0, DQ high-Z, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, last_grant=1.
- Reset asserted mid-access: outputs go to reset values immediately (asynchronous); the access is abandoned with no ack.
- Latency: req first sampled in IDLE at cycle n. SETUP at n+1, STROBE at n+2..n+1+WAIT_CYCLES, ack at n+2+WAIT_CYCLES. Default latency is 4 cycles.
- Throughput: one access per WAIT_CYCLES+3 cycles, 5 at default.
- Strobe and DQ-enable changes occur only on clk edges from flops; no combinational path from any m*_ input to SRAM pins.
- Both ports continuously requesting alternate strictly 0,1,0,1…

## Structure
- Package sram_arbiter_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD)
  - SRAM_ADDR_W=17 and SRAM_DATA_W=8 constants
  - WAIT_CNT_W=4
- Sub-module sram_rr_arbiter: two-request round-robin grant with last_grant register, updated only when the FSM leaves IDLE.
- The top level holds the FSM, wait counter, latched request, pin registers and tri-state.

## Test plan
- Reset, then port 0 writes 0xA5 to 0x1_2345 -> WE_n low exactly 2 cycles, DQ=0xA5 from SETUP through HOLD, m0_ack at cycle n+4, m1_ack stays 0.
- Port 1 reads 0x1_2345 after that write (SRAM model) -> OE_n low 2 cycles, m1_rdata=0xA5 with m1_ack at n+4, DQ never driven by block.
- Both ports request from the same cycle, each for 3 accesses -> grant order 0,1,0,1,0,1, ack spacing 5 cycles, no overlapping strobes.
- WAIT_CYCLES=1 and 15 builds, single read -> ack at n+3 and n+17 respectively.
- Reset asserted during STROBE of a write -> same-cycle CE_n=WE_n=1, DQ high-Z, no ack. After release, a pending req restarts from IDLE with port 0 winning a tie.
- Port 0 changes addr/wdata mid-access (protocol violation) -> SRAM_ADDR and DQ keep latched values until HOLD ends.
